// File: rtl/arb_pkg.sv
// Shared constants, state encoding and the rotating-priority pick helper
// for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Walk from the highest offset down so the lowest offset from ptr wins.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] c;
    p = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      c = ptr + SEL_W'(i);
      if (req[c]) begin
        p.valid = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4_reg.sv
// Registered 4:1 selection of DW-bit operands; holds its value when en is low.
module mux4_reg
  import arb_pkg::*;
#(
  parameter int unsigned DW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [SEL_W-1:0]     sel,
  input  logic [NREQ*DW-1:0]   din,
  output logic [DW-1:0]        f
);

  always_ff @(posedge clk) begin
    if (rst) begin
      f <= '0;
    end else if (en) begin
      f <= din[sel*DW +: DW];
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter for four requesters with a bounded hold time, driving a
// registered 4:1 operand capture one cycle behind the grant.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int unsigned DW       = 2,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]    gnt,
  output logic [SEL_W-1:0]   sel,
  output logic [DW-1:0]      f,
  output logic               f_valid,
  output logic               busy
);

  localparam int unsigned HW = $clog2(MAX_HOLD) + 1;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             f_valid_q;

  pick_t            pick_idle, pick_rel;
  logic [SEL_W-1:0] next_start;
  logic             release_now;

  assign next_start  = sel_q + SEL_W'(1);
  assign pick_idle   = rr_pick(req, ptr_q);
  // Starting after the grantee makes it lowest priority on re-arbitration.
  assign pick_rel    = rr_pick(req, next_start);
  assign release_now = !req[sel_q] || (hold_cnt_q == HW'(MAX_HOLD - 1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_idle.valid) begin
          sel_d      = pick_idle.idx;
          gnt_d      = NREQ'(1) << pick_idle.idx;
          hold_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!release_now) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end else begin
          ptr_d = next_start;
          if (pick_rel.valid) begin
            sel_d      = pick_rel.idx;
            gnt_d      = NREQ'(1) << pick_rel.idx;
            hold_cnt_d = '0;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      sel_q      <= '0;
      f_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      f_valid_q  <= (state_q == ST_GRANT);
    end
  end

  mux4_reg #(
    .DW(DW)
  ) u_mux (
    .clk(clk),
    .rst(rst),
    .en (state_q == ST_GRANT),
    .sel(sel_q),
    .din(din),
    .f  (f)
  );

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign f_valid = f_valid_q;
  assign busy    = |gnt_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: three instances (MAX_HOLD 1..3) share stimulus and are
// compared each cycle against a per-instance grant-history model.
module tb_rr_arb4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] din;

  logic [3:0] gnt_w  [3];
  logic [1:0] sel_w  [3];
  logic [1:0] f_w    [3];
  logic       fv_w   [3];
  logic       busy_w [3];

  int checks = 0;
  int errors = 0;

  // Model state per instance; instance k has MAX_HOLD = k+1.
  int m_busy [3];
  int m_idx  [3];
  int m_ptr  [3];
  int m_hold [3];
  int m_f    [3];
  int m_fv   [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    rr_arb4 #(
      .DW      (2),
      .MAX_HOLD(k + 1)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .din    (din),
      .gnt    (gnt_w[k]),
      .sel    (sel_w[k]),
      .f      (f_w[k]),
      .f_valid(fv_w[k]),
      .busy   (busy_w[k])
    );
  end

  always #5 clk = ~clk;

  function automatic int first_req(input logic [3:0] r, input int start);
    for (int j = 0; j < 4; j++) begin
      if (r[(start + j) % 4]) return (start + j) % 4;
    end
    return -1;
  endfunction

  task automatic model_update();
    int w;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_idx[k] = 0; m_ptr[k] = 0;
        m_hold[k] = 0; m_f[k]   = 0; m_fv[k]  = 0;
      end else begin
        if (m_busy[k] != 0) begin
          m_f[k]  = int'((din >> (2 * m_idx[k])) & 8'h3);
          m_fv[k] = 1;
        end else begin
          m_fv[k] = 0;
        end
        if (m_busy[k] == 0) begin
          w = first_req(req, m_ptr[k]);
          if (w >= 0) begin
            m_busy[k] = 1; m_idx[k] = w; m_hold[k] = 0;
          end
        end else if (!req[m_idx[k]] || m_hold[k] == k) begin
          m_ptr[k] = (m_idx[k] + 1) % 4;
          w = first_req(req, m_ptr[k]);
          if (w >= 0) begin
            m_idx[k] = w; m_hold[k] = 0;
          end else begin
            m_busy[k] = 0;
          end
        end else begin
          m_hold[k]++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s mh=%0d got %0h want %0h", tag, k + 1, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("gnt", k, 32'(gnt_w[k]), (m_busy[k] != 0) ? (32'd1 << m_idx[k]) : 32'd0);
      chk("sel", k, 32'(sel_w[k]), 32'(m_idx[k]));
      chk("f", k, 32'(f_w[k]), 32'(m_f[k]));
      chk("f_valid", k, 32'(fv_w[k]), 32'(m_fv[k]));
      chk("busy", k, 32'(busy_w[k]), 32'(m_busy[k]));
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic [7:0] d);
    rst = r;
    req = q;
    din = d;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  logic [3:0] rot2 [9];
  logic [3:0] rot1 [5];
  logic [7:0] din_id;
  logic [3:0] rq;

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    req    = 4'b1111;
    din_id = 8'b11_10_01_00;
    din    = din_id;
    rot2   = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    rot1   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with all requests pending, then fair rotation.
    step(1'b1, 4'b1111, din_id);
    step(1'b1, 4'b1111, din_id);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 4'b1111, din_id);
      chk("rot_mh2", 1, 32'(gnt_w[1]), 32'(rot2[i]));
      if (i < 5) chk("rot_mh1", 0, 32'(gnt_w[0]), 32'(rot1[i]));
    end

    // Early release of requester 0 moves straight to requester 2.
    step(1'b1, 4'b0000, din_id);
    step(1'b0, 4'b0101, din_id);
    step(1'b0, 4'b0100, din_id);
    chk("early_rel", 2, 32'(gnt_w[2]), 32'h4);

    // Sole requester keeps a continuous grant across forced releases.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b1000, din_id);
      chk("sole_gnt", 2, 32'(gnt_w[2]), 32'h8);
      if (i > 0) chk("sole_fv", 0, 32'(fv_w[0]), 32'h1);
    end

    // All requests drop.
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, din_id);
    chk("drop_sel", 2, 32'(sel_w[2]), 32'h3);

    // Reset in the middle of a grant, then arbitration restarts at 0.
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 8'hA5);
    step(1'b1, 4'b0100, 8'hA5);
    chk("rst_mid_gnt", 2, 32'(gnt_w[2]), 32'h0);
    step(1'b0, 4'b1111, 8'h5A);
    chk("post_rst", 2, 32'(gnt_w[2]), 32'h1);

    // Randomized traffic; requests often persist to exercise hold limits.
    rq = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom());
      step(($urandom_range(0, 39) == 0), rq, 8'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
